// File: rtl/tlb_request_arbiter_pkg.sv
// Shared TLB defines: page index and ASID types, the TLB command encoding,
// and a small helper that separates maintenance commands from lookups.
package tlb_request_arbiter_pkg;

    localparam int PAGE_INDEX_WIDTH = 20;
    localparam int ASID_WIDTH       = 8;

    typedef logic [PAGE_INDEX_WIDTH-1:0] page_index_t;
    typedef logic [ASID_WIDTH-1:0]       asid_t;

    typedef enum logic [1:0] {
        LOOKUP         = 2'd0,
        UPDATE         = 2'd1,
        INVALIDATE     = 2'd2,
        INVALIDATE_ALL = 2'd3
    } tlb_cmd_t;

    function automatic logic is_maintenance(input tlb_cmd_t cmd);
        return cmd != LOOKUP;
    endfunction

endpackage

// File: rtl/tlb_request_arbiter_if.sv
// Requester-side bus of the TLB arbiter: one valid/ready handshake plus a
// command payload per requester port.
interface tlb_request_arbiter_if #(
    parameter int NUM_REQUESTERS = 4
);
    import tlb_request_arbiter_pkg::*;

    logic [NUM_REQUESTERS-1:0] req_valid;
    logic [NUM_REQUESTERS-1:0] req_ready;
    tlb_cmd_t                  req_cmd        [NUM_REQUESTERS];
    page_index_t               req_vpage_idx  [NUM_REQUESTERS];
    asid_t                     req_asid       [NUM_REQUESTERS];
    page_index_t               req_ppage_idx  [NUM_REQUESTERS];
    logic [NUM_REQUESTERS-1:0] req_present;
    logic [NUM_REQUESTERS-1:0] req_exe_writable;
    logic [NUM_REQUESTERS-1:0] req_supervisor;
    logic [NUM_REQUESTERS-1:0] req_global;

    modport master (
        output req_valid, req_cmd, req_vpage_idx, req_asid, req_ppage_idx,
               req_present, req_exe_writable, req_supervisor, req_global,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_cmd, req_vpage_idx, req_asid, req_ppage_idx,
               req_present, req_exe_writable, req_supervisor, req_global,
        output req_ready
    );

endinterface

// File: rtl/tlb_request_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer that
// moves just past the winner whenever the grant is taken.
module rr_arbiter #(
    parameter  int WIDTH     = 4,
    localparam int IDX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     req,
    input  logic                 advance,
    output logic [WIDTH-1:0]     grant,
    output logic [IDX_WIDTH-1:0] grant_idx
);

    logic [IDX_WIDTH-1:0] ptr;

    always_comb begin
        int                   idx;
        logic [IDX_WIDTH-1:0] idx_sel;
        logic                 found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        idx_sel   = '0;
        for (int off = 0; off < WIDTH; off++) begin
            idx = int'(ptr) + off;
            if (idx >= WIDTH) begin
                idx = idx - WIDTH;
            end
            idx_sel = IDX_WIDTH'(idx);
            if (!found && req[idx_sel]) begin
                grant[idx_sel] = 1'b1;
                grant_idx      = idx_sel;
                found          = 1'b1;
            end
        end
    end

    // The pointer only moves on a taken grant, so an idle class keeps its turn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            if (grant_idx == IDX_WIDTH'(WIDTH - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + IDX_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/tlb_request_arbiter.sv
// Arbitrates TLB commands from several requesters: maintenance beats lookups
// unless lookups have starved, and one completion is returned per grant.
module tlb_request_arbiter
    import tlb_request_arbiter_pkg::*;
#(
    parameter  int NUM_REQUESTERS = 4,
    parameter  int STARVE_LIMIT   = 8,
    localparam int ID_WIDTH       = $clog2(NUM_REQUESTERS),
    localparam int COUNT_WIDTH    = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    tlb_request_arbiter_if.slave    req_bus,

    output logic                    tlb_lookup_en,
    output logic                    tlb_update_en,
    output logic                    tlb_invalidate_en,
    output logic                    tlb_invalidate_all_en,
    output page_index_t             tlb_request_vpage_idx,
    output asid_t                   tlb_request_asid,
    output page_index_t             tlb_update_ppage_idx,
    output logic                    tlb_update_present,
    output logic                    tlb_update_exe_writable,
    output logic                    tlb_update_supervisor,
    output logic                    tlb_update_global,

    input  page_index_t             tlb_lookup_ppage_idx,
    input  logic                    tlb_lookup_hit,
    input  logic                    tlb_lookup_present,
    input  logic                    tlb_lookup_exe_writable,
    input  logic                    tlb_lookup_supervisor,

    output logic                    resp_valid,
    output logic [ID_WIDTH-1:0]     resp_id,
    output tlb_cmd_t                resp_cmd,
    output logic                    resp_hit,
    output page_index_t             resp_ppage_idx,
    output logic                    resp_present,
    output logic                    resp_exe_writable,
    output logic                    resp_supervisor
);

    logic [NUM_REQUESTERS-1:0] lookup_req;
    logic [NUM_REQUESTERS-1:0] maint_req;
    logic [NUM_REQUESTERS-1:0] lookup_grant;
    logic [NUM_REQUESTERS-1:0] maint_grant;
    logic [ID_WIDTH-1:0]       lookup_idx;
    logic [ID_WIDTH-1:0]       maint_idx;
    logic [ID_WIDTH-1:0]       grant_idx;
    logic                      lookup_sel;
    logic                      maint_sel;
    logic                      any_grant;
    logic                      starve_flag;
    logic                      resp_is_lookup;
    logic [COUNT_WIDTH-1:0]    starve_count;
    tlb_cmd_t                  grant_cmd;

    always_comb begin
        lookup_req = '0;
        maint_req  = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            lookup_req[i] = req_bus.req_valid[i] && !is_maintenance(req_bus.req_cmd[i]);
            maint_req[i]  = req_bus.req_valid[i] &&  is_maintenance(req_bus.req_cmd[i]);
        end
    end

    assign starve_flag = (starve_count == COUNT_WIDTH'(STARVE_LIMIT));

    // Class choice; reset masks it so ready and the strobes drop immediately.
    always_comb begin
        lookup_sel = 1'b0;
        maint_sel  = 1'b0;
        if (!reset) begin
            if ((|lookup_req) && (starve_flag || !(|maint_req))) begin
                lookup_sel = 1'b1;
            end else if (|maint_req) begin
                maint_sel = 1'b1;
            end
        end
    end

    assign any_grant = lookup_sel || maint_sel;
    assign grant_idx = lookup_sel ? lookup_idx : maint_idx;

    always_comb begin
        req_bus.req_ready = '0;
        if (lookup_sel) begin
            req_bus.req_ready = lookup_grant;
        end else if (maint_sel) begin
            req_bus.req_ready = maint_grant;
        end
    end

    rr_arbiter #(.WIDTH(NUM_REQUESTERS)) u_lookup_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (lookup_req),
        .advance   (lookup_sel),
        .grant     (lookup_grant),
        .grant_idx (lookup_idx)
    );

    rr_arbiter #(.WIDTH(NUM_REQUESTERS)) u_maint_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (maint_req),
        .advance   (maint_sel),
        .grant     (maint_grant),
        .grant_idx (maint_idx)
    );

    // Command bus to the TLB is steered from the winner and zeroed when idle.
    always_comb begin
        grant_cmd               = req_bus.req_cmd[grant_idx];
        tlb_lookup_en           = any_grant && (grant_cmd == LOOKUP);
        tlb_update_en           = any_grant && (grant_cmd == UPDATE);
        tlb_invalidate_en       = any_grant && (grant_cmd == INVALIDATE);
        tlb_invalidate_all_en   = any_grant && (grant_cmd == INVALIDATE_ALL);
        tlb_request_vpage_idx   = '0;
        tlb_request_asid        = '0;
        tlb_update_ppage_idx    = '0;
        tlb_update_present      = 1'b0;
        tlb_update_exe_writable = 1'b0;
        tlb_update_supervisor   = 1'b0;
        tlb_update_global       = 1'b0;
        if (any_grant) begin
            tlb_request_vpage_idx   = req_bus.req_vpage_idx[grant_idx];
            tlb_request_asid        = req_bus.req_asid[grant_idx];
            tlb_update_ppage_idx    = req_bus.req_ppage_idx[grant_idx];
            tlb_update_present      = req_bus.req_present[grant_idx];
            tlb_update_exe_writable = req_bus.req_exe_writable[grant_idx];
            tlb_update_supervisor   = req_bus.req_supervisor[grant_idx];
            tlb_update_global       = req_bus.req_global[grant_idx];
        end
    end

    // Saturating count of lookup-pending cycles lost to maintenance traffic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_count <= '0;
        end else if (lookup_sel) begin
            starve_count <= '0;
        end else if (|lookup_req) begin
            if (!starve_flag) begin
                starve_count <= starve_count + COUNT_WIDTH'(1);
            end
        end else begin
            starve_count <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_cmd   <= LOOKUP;
        end else begin
            resp_valid <= any_grant;
            if (any_grant) begin
                resp_id  <= grant_idx;
                resp_cmd <= grant_cmd;
            end
        end
    end

    // The TLB result lines are only meaningful for a completing lookup.
    assign resp_is_lookup    = resp_valid && (resp_cmd == LOOKUP);
    assign resp_hit          = resp_is_lookup && tlb_lookup_hit;
    assign resp_ppage_idx    = resp_is_lookup ? tlb_lookup_ppage_idx : '0;
    assign resp_present      = resp_is_lookup && tlb_lookup_present;
    assign resp_exe_writable = resp_is_lookup && tlb_lookup_exe_writable;
    assign resp_supervisor   = resp_is_lookup && tlb_lookup_supervisor;

endmodule

// File: tb/tb_tlb_request_arbiter.sv
// Directed bench for tlb_request_arbiter with a small behavioural TLB that
// returns lookup results one cycle after the command strobe.
module tb_tlb_request_arbiter;
    import tlb_request_arbiter_pkg::*;

    localparam int N = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tlb_request_arbiter_if #(.NUM_REQUESTERS(N)) bus ();

    logic        tlb_lookup_en, tlb_update_en, tlb_invalidate_en, tlb_invalidate_all_en;
    page_index_t tlb_request_vpage_idx, tlb_update_ppage_idx, tlb_lookup_ppage_idx;
    asid_t       tlb_request_asid;
    logic        tlb_update_present, tlb_update_exe_writable, tlb_update_supervisor, tlb_update_global;
    logic        tlb_lookup_hit, tlb_lookup_present, tlb_lookup_exe_writable, tlb_lookup_supervisor;
    logic        resp_valid, resp_hit, resp_present, resp_exe_writable, resp_supervisor;
    logic [1:0]  resp_id;
    tlb_cmd_t    resp_cmd;
    page_index_t resp_ppage_idx;

    tlb_request_arbiter #(.NUM_REQUESTERS(N), .STARVE_LIMIT(8)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .req_bus                 (bus),
        .tlb_lookup_en           (tlb_lookup_en),
        .tlb_update_en           (tlb_update_en),
        .tlb_invalidate_en       (tlb_invalidate_en),
        .tlb_invalidate_all_en   (tlb_invalidate_all_en),
        .tlb_request_vpage_idx   (tlb_request_vpage_idx),
        .tlb_request_asid        (tlb_request_asid),
        .tlb_update_ppage_idx    (tlb_update_ppage_idx),
        .tlb_update_present      (tlb_update_present),
        .tlb_update_exe_writable (tlb_update_exe_writable),
        .tlb_update_supervisor   (tlb_update_supervisor),
        .tlb_update_global       (tlb_update_global),
        .tlb_lookup_ppage_idx    (tlb_lookup_ppage_idx),
        .tlb_lookup_hit          (tlb_lookup_hit),
        .tlb_lookup_present      (tlb_lookup_present),
        .tlb_lookup_exe_writable (tlb_lookup_exe_writable),
        .tlb_lookup_supervisor   (tlb_lookup_supervisor),
        .resp_valid              (resp_valid),
        .resp_id                 (resp_id),
        .resp_cmd                (resp_cmd),
        .resp_hit                (resp_hit),
        .resp_ppage_idx          (resp_ppage_idx),
        .resp_present            (resp_present),
        .resp_exe_writable       (resp_exe_writable),
        .resp_supervisor         (resp_supervisor)
    );

    // Behavioural TLB: 16 direct-mapped entries, result registered on lookup.
    typedef struct packed {
        logic        valid;
        page_index_t vpage;
        asid_t       asid;
        page_index_t ppage;
        logic        present;
        logic        exe_writable;
        logic        supervisor;
        logic        global_page;
    } model_entry_t;

    model_entry_t model_mem [16];
    model_entry_t probe;
    logic         probe_hit;
    logic [3:0]   probe_set;

    assign probe_set = tlb_request_vpage_idx[3:0];
    assign probe     = model_mem[probe_set];
    assign probe_hit = probe.valid && (probe.vpage == tlb_request_vpage_idx) &&
                       (probe.global_page || (probe.asid == tlb_request_asid));

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) model_mem[i] <= '0;
            tlb_lookup_hit          <= 1'b0;
            tlb_lookup_ppage_idx    <= '0;
            tlb_lookup_present      <= 1'b0;
            tlb_lookup_exe_writable <= 1'b0;
            tlb_lookup_supervisor   <= 1'b0;
        end else begin
            if (tlb_lookup_en) begin
                tlb_lookup_hit          <= probe_hit;
                tlb_lookup_ppage_idx    <= probe_hit ? probe.ppage : '0;
                tlb_lookup_present      <= probe_hit && probe.present;
                tlb_lookup_exe_writable <= probe_hit && probe.exe_writable;
                tlb_lookup_supervisor   <= probe_hit && probe.supervisor;
            end
            if (tlb_update_en) begin
                model_mem[probe_set] <= '{valid: 1'b1, vpage: tlb_request_vpage_idx,
                                          asid: tlb_request_asid, ppage: tlb_update_ppage_idx,
                                          present: tlb_update_present,
                                          exe_writable: tlb_update_exe_writable,
                                          supervisor: tlb_update_supervisor,
                                          global_page: tlb_update_global};
            end
            if (tlb_invalidate_en && probe_hit) model_mem[probe_set].valid <= 1'b0;
            if (tlb_invalidate_all_en) begin
                for (int i = 0; i < 16; i++) model_mem[i].valid <= 1'b0;
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] id, input tlb_cmd_t cmd, input page_index_t vpage,
                                 input asid_t asid, input page_index_t ppage, input logic [3:0] attrs);
        bus.req_valid[id]        = 1'b1;
        bus.req_cmd[id]          = cmd;
        bus.req_vpage_idx[id]    = vpage;
        bus.req_asid[id]         = asid;
        bus.req_ppage_idx[id]    = ppage;
        bus.req_present[id]      = attrs[3];
        bus.req_exe_writable[id] = attrs[2];
        bus.req_supervisor[id]   = attrs[1];
        bus.req_global[id]       = attrs[0];
    endtask

    task automatic drop_request(input logic [1:0] id);
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Every cycle: strobes and ready one-hot-or-zero, one response per grant.
    logic       prev_grant = 1'b0;
    logic [1:0] prev_id    = '0;
    always @(negedge clk) begin
        checkOutput("strobe_onehot0", 32'($onehot0({tlb_lookup_en, tlb_update_en,
                                                    tlb_invalidate_en, tlb_invalidate_all_en})), 32'd1);
        checkOutput("ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
        if (reset) begin
            checkOutput("resp_in_reset", 32'(resp_valid), 32'd0);
        end else begin
            checkOutput("resp_follows_grant", 32'(resp_valid), 32'(prev_grant));
            if (prev_grant) checkOutput("resp_id_of_grant", 32'(resp_id), 32'(prev_id));
        end
        prev_grant = !reset && (|(bus.req_valid & bus.req_ready));
        prev_id    = '0;
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) prev_id = 2'(i);
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: bench did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bus.req_valid = '0;
        for (int i = 0; i < N; i++) applyStimulus(2'(i), LOOKUP, '0, '0, '0, 4'b0000);
        bus.req_valid = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("reset_strobes", 32'({tlb_lookup_en, tlb_update_en, tlb_invalidate_en, tlb_invalidate_all_en}), 32'd0);
        checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
        next_cycle;
        reset = 1'b0;

        $display("[TB] four requesters looking up continuously");
        for (int i = 0; i < N; i++) applyStimulus(2'(i), LOOKUP, 20'('h100 + i), 8'd1, '0, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("rr_lookup_ready", 32'(bus.req_ready), 32'd1 << (k % 4));
            checkOutput("rr_lookup_vpage", 32'(tlb_request_vpage_idx), 32'('h100 + (k % 4)));
            if (k > 0) checkOutput("rr_resp_id", 32'(resp_id), 32'((k - 1) % 4));
            next_cycle;
        end
        bus.req_valid = '0;
        @(negedge clk);
        checkOutput("rr_last_resp_id", 32'(resp_id), 32'd0);
        checkOutput("rr_last_resp_cmd", 32'(resp_cmd), 32'(LOOKUP));
        next_cycle;

        $display("[TB] update then lookup of the same page");
        applyStimulus(2'd1, UPDATE, 20'h12, 8'd5, 20'h34, 4'b1100);
        applyStimulus(2'd0, LOOKUP, 20'h12, 8'd5, '0, 4'b0000);
        @(negedge clk);
        checkOutput("upd_ready", 32'(bus.req_ready), 32'b0010);
        checkOutput("upd_update_en", 32'(tlb_update_en), 32'd1);
        checkOutput("upd_lookup_en", 32'(tlb_lookup_en), 32'd0);
        checkOutput("upd_vpage", 32'(tlb_request_vpage_idx), 32'h12);
        checkOutput("upd_asid", 32'(tlb_request_asid), 32'd5);
        checkOutput("upd_ppage", 32'(tlb_update_ppage_idx), 32'h34);
        checkOutput("upd_attrs", 32'({tlb_update_present, tlb_update_exe_writable,
                                      tlb_update_supervisor, tlb_update_global}), 32'b1100);
        next_cycle;
        drop_request(2'd1);
        @(negedge clk);
        checkOutput("upd_then_lookup_ready", 32'(bus.req_ready), 32'b0001);
        checkOutput("upd_then_lookup_en", 32'(tlb_lookup_en), 32'd1);
        checkOutput("upd_resp_cmd", 32'(resp_cmd), 32'(UPDATE));
        checkOutput("upd_resp_id", 32'(resp_id), 32'd1);
        checkOutput("upd_resp_hit", 32'(resp_hit), 32'd0);
        next_cycle;
        drop_request(2'd0);
        @(negedge clk);
        checkOutput("bypass_resp_cmd", 32'(resp_cmd), 32'(LOOKUP));
        checkOutput("bypass_resp_hit", 32'(resp_hit), 32'd1);
        checkOutput("bypass_resp_ppage", 32'(resp_ppage_idx), 32'h34);
        checkOutput("bypass_resp_attrs", 32'({resp_present, resp_exe_writable, resp_supervisor}), 32'b110);
        checkOutput("idle_strobes", 32'({tlb_lookup_en, tlb_update_en, tlb_invalidate_en, tlb_invalidate_all_en}), 32'd0);
        next_cycle;

        $display("[TB] lookup starved by continuous updates");
        applyStimulus(2'd2, UPDATE, 20'h50, 8'd1, 20'h55, 4'b1000);
        applyStimulus(2'd3, UPDATE, 20'h60, 8'd1, 20'h66, 4'b1000);
        applyStimulus(2'd0, LOOKUP, 20'h40, 8'd1, '0, 4'b0000);
        for (int w = 0; w < 2; w++) begin
            for (int c = 0; c < 9; c++) begin
                @(negedge clk);
                if (c < 8) begin
                    checkOutput("starve_maint_ready", 32'(bus.req_ready), (c % 2 == 0) ? 32'b0100 : 32'b1000);
                    checkOutput("starve_lookup_held", 32'(tlb_lookup_en), 32'd0);
                end else begin
                    checkOutput("starve_lookup_ready", 32'(bus.req_ready), 32'b0001);
                    checkOutput("starve_lookup_en", 32'(tlb_lookup_en), 32'd1);
                end
                next_cycle;
                if (c == 8) applyStimulus(2'd0, LOOKUP, 20'h41, 8'd1, '0, 4'b0000);
            end
        end
        bus.req_valid = '0;
        @(negedge clk);
        checkOutput("starve_resp_cmd", 32'(resp_cmd), 32'(LOOKUP));
        checkOutput("starve_resp_hit", 32'(resp_hit), 32'd0);
        next_cycle;

        $display("[TB] invalidate-all hides a filled page");
        applyStimulus(2'd0, LOOKUP, 20'h12, 8'd5, '0, 4'b0000);
        @(negedge clk);
        checkOutput("prefill_ready", 32'(bus.req_ready), 32'b0001);
        next_cycle;
        drop_request(2'd0);
        @(negedge clk);
        checkOutput("prefill_hit", 32'(resp_hit), 32'd1);
        checkOutput("prefill_ppage", 32'(resp_ppage_idx), 32'h34);
        next_cycle;
        applyStimulus(2'd3, INVALIDATE_ALL, '0, '0, '0, 4'b0000);
        applyStimulus(2'd0, LOOKUP, 20'h12, 8'd5, '0, 4'b0000);
        @(negedge clk);
        checkOutput("inv_all_ready", 32'(bus.req_ready), 32'b1000);
        checkOutput("inv_all_en", 32'(tlb_invalidate_all_en), 32'd1);
        next_cycle;
        drop_request(2'd3);
        @(negedge clk);
        checkOutput("inv_all_lookup_ready", 32'(bus.req_ready), 32'b0001);
        checkOutput("inv_all_resp_cmd", 32'(resp_cmd), 32'(INVALIDATE_ALL));
        checkOutput("inv_all_resp_id", 32'(resp_id), 32'd3);
        next_cycle;
        drop_request(2'd0);
        @(negedge clk);
        checkOutput("inv_all_lookup_cmd", 32'(resp_cmd), 32'(LOOKUP));
        checkOutput("inv_all_lookup_hit", 32'(resp_hit), 32'd0);
        checkOutput("inv_all_lookup_ppage", 32'(resp_ppage_idx), 32'd0);
        next_cycle;

        applyStimulus(2'd2, INVALIDATE, 20'h07, 8'd1, '0, 4'b0000);
        @(negedge clk);
        checkOutput("inv_ready", 32'(bus.req_ready), 32'b0100);
        checkOutput("inv_en", 32'(tlb_invalidate_en), 32'd1);
        next_cycle;
        drop_request(2'd2);
        @(negedge clk);
        checkOutput("inv_resp_cmd", 32'(resp_cmd), 32'(INVALIDATE));
        next_cycle;

        $display("[TB] reset with a response in flight");
        applyStimulus(2'd1, LOOKUP, 20'h99, 8'd2, '0, 4'b0000);
        @(negedge clk);
        checkOutput("pre_reset_ready", 32'(bus.req_ready), 32'b0010);
        next_cycle;
        drop_request(2'd1);
        reset = 1'b1;
        #1;
        checkOutput("reset_drops_resp", 32'(resp_valid), 32'd0);
        applyStimulus(2'd3, UPDATE, 20'h70, 8'd1, 20'h77, 4'b1000);
        @(negedge clk);
        checkOutput("reset_masks_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("reset_masks_strobe", 32'(tlb_update_en), 32'd0);
        drop_request(2'd3);
        next_cycle;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_resp", 32'(resp_valid), 32'd0);
        checkOutput("post_reset_strobes", 32'({tlb_lookup_en, tlb_update_en, tlb_invalidate_en, tlb_invalidate_all_en}), 32'd0);
        next_cycle;
        applyStimulus(2'd1, UPDATE, 20'h21, 8'd1, 20'h22, 4'b1000);
        applyStimulus(2'd3, UPDATE, 20'h23, 8'd1, 20'h24, 4'b1000);
        @(negedge clk);
        checkOutput("maint_ptr_restart", 32'(bus.req_ready), 32'b0010);
        next_cycle;
        drop_request(2'd1);
        @(negedge clk);
        checkOutput("maint_ptr_next", 32'(bus.req_ready), 32'b1000);
        next_cycle;
        drop_request(2'd3);
        applyStimulus(2'd0, LOOKUP, 20'h30, 8'd1, '0, 4'b0000);
        applyStimulus(2'd3, LOOKUP, 20'h31, 8'd1, '0, 4'b0000);
        @(negedge clk);
        checkOutput("lookup_ptr_restart", 32'(bus.req_ready), 32'b0001);
        next_cycle;
        drop_request(2'd0);
        @(negedge clk);
        checkOutput("lookup_ptr_next", 32'(bus.req_ready), 32'b1000);
        next_cycle;
        drop_request(2'd3);
        @(negedge clk);
        checkOutput("final_resp_id", 32'(resp_id), 32'd3);
        next_cycle;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
